// File: rtl/sine_sd_dac_if.sv
// Strobe and output bundle for the sine_sd_dac audio test-tone source.
// The master drives the phase/sample strobes and the slave returns the sine, sample and bitstream.
interface sine_sd_dac_if #(
   parameter int SAMPLE_WIDTH = 16
) ();
   logic                    phase_en;
   logic                    sample_en;
   logic [7:0]              sine_out;
   logic [SAMPLE_WIDTH-1:0] sample_out;
   logic                    sd_out;

   modport master (
      output phase_en, sample_en,
      input  sine_out, sample_out, sd_out
   );

   modport slave (
      input  phase_en, sample_en,
      output sine_out, sample_out, sd_out
   );
endinterface

// File: rtl/sine_sd_dac.sv
// Quarter-wave sine generator -> sample latch -> first-order sigma-delta 1-bit DAC.
// Define SDDAC_DITHER_EN to feed LFSR dither into the modulator carry-in.
module sine_sd_dac #(
   parameter int PHASE_BITS   = 8,
   parameter int SAMPLE_WIDTH = 16
) (
   input logic          clk,
   input logic          rst,
   sine_sd_dac_if.slave bus
);

   // round(127*sin(2*pi*k/256)) for k = 0..64; finer phase bits below the top 8 do not index the table
   localparam logic [6:0] QTAB [0:64] = '{
      7'd0,   7'd3,   7'd6,   7'd9,   7'd12,  7'd16,  7'd19,  7'd22,  7'd25,  7'd28,  7'd31,  7'd34,  7'd37,
      7'd40,  7'd43,  7'd46,  7'd49,  7'd51,  7'd54,  7'd57,  7'd60,  7'd63,  7'd65,  7'd68,  7'd71,
      7'd73,  7'd76,  7'd78,  7'd81,  7'd83,  7'd85,  7'd88,  7'd90,  7'd92,  7'd94,  7'd96,  7'd98,
      7'd100, 7'd102, 7'd104, 7'd106, 7'd107, 7'd109, 7'd111, 7'd112, 7'd113, 7'd115, 7'd116, 7'd117,
      7'd118, 7'd120, 7'd121, 7'd122, 7'd122, 7'd123, 7'd124, 7'd125, 7'd125, 7'd126, 7'd126, 7'd126,
      7'd127, 7'd127, 7'd127, 7'd127
   };

   logic [PHASE_BITS-1:0]   phase_q, phase_d;
   logic [7:0]              top8;
   logic [6:0]              t_idx;
   logic [6:0]              mag;
   logic [7:0]              sine_q, sine_d;
   logic [SAMPLE_WIDTH-1:0] sample_q, sample_d;
   logic [SAMPLE_WIDTH-1:0] u;
   logic [SAMPLE_WIDTH:0]   acc_q, acc_d;
   logic                    sd_q;
   logic                    cin;

   always_comb begin
      phase_d  = bus.phase_en ? phase_q + 1'b1 : phase_q;
      top8     = phase_q[PHASE_BITS-1 -: 8];
      // second and fourth quadrants read the table backwards, lower half-period is negated
      t_idx    = top8[6] ? 7'd64 - {1'b0, top8[5:0]} : {1'b0, top8[5:0]};
      mag      = QTAB[t_idx];
      sine_d   = top8[7] ? 8'(-{1'b0, mag}) : {1'b0, mag};
      sample_d = bus.sample_en ? {sine_q[7], sine_q, {(SAMPLE_WIDTH-9){1'b0}}} : sample_q;
      u        = {~sample_q[SAMPLE_WIDTH-1], sample_q[SAMPLE_WIDTH-2:0]};
      acc_d    = {1'b0, acc_q[SAMPLE_WIDTH-1:0]} + {1'b0, u} + {{SAMPLE_WIDTH{1'b0}}, cin};
   end

`ifdef SDDAC_DITHER_EN
   logic [15:0] lfsr_q, lfsr_d;

   always_comb lfsr_d = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};

   always_ff @(posedge clk or posedge rst) begin
      if (rst) lfsr_q <= 16'hACE1;
      else     lfsr_q <= lfsr_d;
   end

   assign cin = lfsr_q[0];
`else
   assign cin = 1'b0;
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         phase_q  <= '0;
         sine_q   <= '0;
         sample_q <= '0;
         acc_q    <= '0;
         sd_q     <= 1'b0;
      end else begin
         phase_q  <= phase_d;
         sine_q   <= sine_d;
         sample_q <= sample_d;
         acc_q    <= acc_d;
         sd_q     <= acc_d[SAMPLE_WIDTH];
      end
   end

   assign bus.sine_out   = sine_q;
   assign bus.sample_out = sample_q;
   assign bus.sd_out     = sd_q;

endmodule

// File: tb/tb_sine_sd_dac.sv
// Directed self-checking bench for sine_sd_dac with a queue-based scoreboard.
module tb_sine_sd_dac;

   logic clk;
   logic rst;

   sine_sd_dac_if #(.SAMPLE_WIDTH(16)) bus ();

   sine_sd_dac #(.PHASE_BITS(8), .SAMPLE_WIDTH(16)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   typedef struct {
      string       tag;
      logic [31:0] exp;
   } exp_t;

   exp_t sb[$];
   int   n_assert = 0;
   int   n_fail   = 0;
   int   ones;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic int ref_sine(input int p);
      real v;
      v = 127.0 * $sin(2.0 * 3.14159265358979 * real'(p) / 256.0);
      if (v >= 0.0) return $rtoi(v + 0.5);
      else          return -$rtoi(0.5 - v);
   endfunction

   function automatic logic [31:0] ref_sample(input int s);
      return 32'((s * 128) & 32'hFFFF);
   endfunction

   task automatic expect_val(input string tag, input logic [31:0] e);
      exp_t x;
      x.tag = tag;
      x.exp = e;
      sb.push_back(x);
   endtask

   task automatic check(input logic [31:0] obs);
      exp_t x;
      n_assert++;
      if (sb.size() == 0) begin
         n_fail++;
         $error("FAIL scoreboard_empty: observed %0h with no expected entry", obs);
      end else begin
         x = sb.pop_front();
         assert (obs === x.exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", x.tag, obs, x.exp);
         end
      end
   endtask

   task automatic step_phase(input int n);
      bus.phase_en = 1'b1;
      repeat (n) @(posedge clk);
      #1 bus.phase_en = 1'b0;
   endtask

   task automatic idle(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic pulse_sample();
      bus.sample_en = 1'b1;
      @(posedge clk);
      #1 bus.sample_en = 1'b0;
   endtask

   task automatic count_ones(input int n);
      ones = 0;
      repeat (n) begin
         @(posedge clk);
         #1;
         if (bus.sd_out) ones++;
      end
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached, %0d failures so far", n_fail);
      $fatal(1, "time limit");
   end

   initial begin
      rst           = 1'b1;
      bus.phase_en  = 1'b0;
      bus.sample_en = 1'b0;
      idle(3);

      expect_val("rst_sine", 32'h0);      check(32'(bus.sine_out));
      expect_val("rst_sample", 32'h0);    check(32'(bus.sample_out));
      expect_val("rst_sd", 32'h0);        check(32'(bus.sd_out));

      @(negedge clk) rst = 1'b0;
      for (int i = 0; i < 8; i++) begin
         expect_val("sd_idle_pattern", 32'(i % 2));
         @(posedge clk);
         #1 check(32'(bus.sd_out));
      end
      expect_val("idle_sine", 32'h0);     check(32'(bus.sine_out));
      expect_val("idle_sample", 32'h0);   check(32'(bus.sample_out));

      // full sweep: phase_en held, sine_out trails phase by one edge
      bus.phase_en = 1'b1;
      for (int j = 1; j <= 256; j++) begin
         expect_val("sweep_sine", 32'(ref_sine(j - 1) & 255));
         if (j - 1 == 0)   expect_val("sine_p0", 32'h00);
         if (j - 1 == 32)  expect_val("sine_p32", 32'd90);
         if (j - 1 == 64)  expect_val("sine_p64", 32'd127);
         if (j - 1 == 128) expect_val("sine_p128", 32'h00);
         if (j - 1 == 192) expect_val("sine_p192", 32'h81);
         @(posedge clk);
         #1;
         while (sb.size() > 0) check(32'(bus.sine_out));
      end
      bus.phase_en = 1'b0;
      expect_val("wrap_sine", 32'h0);
      idle(1);
      check(32'(bus.sine_out));

      // positive peak, latched and modulated over a full period
      step_phase(64);
      expect_val("peak_sine", 32'd127);
      idle(1);
      check(32'(bus.sine_out));
      expect_val("peak_sample", 32'h3F80);
      pulse_sample();
      check(32'(bus.sample_out));
      expect_val("peak_ones_65536", 32'd49024);
      count_ones(65536);
      check(32'(ones));

      // negative peak; u = 0x4080 is a multiple of 16 so 4096 cycles give exactly u/16 ones
      step_phase(128);
      expect_val("trough_sine", 32'h81);
      idle(1);
      check(32'(bus.sine_out));
      expect_val("trough_sample", 32'hC080);
      pulse_sample();
      check(32'(bus.sample_out));
      expect_val("trough_ones_4096", 32'd1032);
      count_ones(4096);
      check(32'(ones));

      // async reset in the middle of a 0x3F80 stream
      step_phase(128);
      expect_val("pre_rst_sine", 32'd127);
      idle(1);
      check(32'(bus.sine_out));
      expect_val("pre_rst_sample", 32'h3F80);
      pulse_sample();
      check(32'(bus.sample_out));
      idle(5);
      #2 rst = 1'b1;
      #1;
      expect_val("async_rst_sample", 32'h0); check(32'(bus.sample_out));
      expect_val("async_rst_sd", 32'h0);     check(32'(bus.sd_out));
      expect_val("async_rst_sine", 32'h0);   check(32'(bus.sine_out));
      @(negedge clk) rst = 1'b0;
      for (int i = 0; i < 6; i++) begin
         expect_val("sd_after_rst", 32'(i % 2));
         @(posedge clk);
         #1 check(32'(bus.sd_out));
      end

      // simultaneous strobes: the latch takes the pre-update sine value
      step_phase(63);
      expect_val("p63_sine", 32'(ref_sine(63) & 255));
      idle(1);
      check(32'(bus.sine_out));
      expect_val("same_cycle_p63", ref_sample(ref_sine(63)));
      bus.phase_en  = 1'b1;
      bus.sample_en = 1'b1;
      @(posedge clk);
      #1;
      bus.phase_en  = 1'b0;
      bus.sample_en = 1'b0;
      check(32'(bus.sample_out));

      step_phase(36);
      expect_val("p100_sine", 32'(ref_sine(100) & 255));
      idle(1);
      check(32'(bus.sine_out));
      expect_val("same_cycle_p100", ref_sample(ref_sine(100)));
      bus.phase_en  = 1'b1;
      bus.sample_en = 1'b1;
      @(posedge clk);
      #1;
      bus.phase_en  = 1'b0;
      bus.sample_en = 1'b0;
      check(32'(bus.sample_out));
      expect_val("p101_sine", 32'(ref_sine(101) & 255));
      idle(1);
      check(32'(bus.sine_out));

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
